// File: rtl/lsu_stage.sv
// Multicycle load/store stage: latches execute results, runs one data-memory
// request/response per load or store, and hands one aligned result to writeback.
module lsu_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  opcode,
  input  logic [2:0]  func3,
  input  logic [31:0] exu_res,
  input  logic [31:0] store_data,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  output logic        mem_req_wen,
  output logic [31:0] mem_req_wdata,
  output logic [3:0]  mem_req_wstrb,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  input  logic        mem_resp_err,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_err
);

  localparam int unsigned XLEN      = 32;
  localparam logic [6:0]  OPC_LOAD  = 7'b0000011;
  localparam logic [6:0]  OPC_STORE = 7'b0100011;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

  state_e           state_q;
  logic [2:0]       func3_q;
  logic [1:0]       off_q;
  logic             in_ready_q;
  logic             req_valid_q;
  logic [XLEN-1:0]  req_addr_q;
  logic             req_wen_q;
  logic [XLEN-1:0]  req_wdata_q;
  logic [3:0]       req_wstrb_q;
  logic             out_valid_q;
  logic [XLEN-1:0]  out_data_q;
  logic             out_err_q;

  logic             is_load_c, is_store_c, legal_c, misal_c;
  logic [XLEN-1:0]  wdata_c, shifted_c, load_data_c;
  logic [3:0]       wstrb_c;

  // Decode of the incoming instruction: legality, alignment and store lanes
  always_comb begin
    is_load_c  = (opcode == OPC_LOAD);
    is_store_c = (opcode == OPC_STORE);
    legal_c    = 1'b0;
    wdata_c    = '0;
    wstrb_c    = 4'b0000;
    if (is_load_c) begin
      legal_c = (func3 == 3'b000) || (func3 == 3'b001) || (func3 == 3'b010) ||
                (func3 == 3'b100) || (func3 == 3'b101);
    end else if (is_store_c) begin
      legal_c = (func3 == 3'b000) || (func3 == 3'b001) || (func3 == 3'b010);
    end
    misal_c = ((func3[1:0] == 2'b01) && exu_res[0]) ||
              ((func3[1:0] == 2'b10) && (exu_res[1:0] != 2'b00));
    if (is_store_c) begin
      case (func3[1:0])
        2'b00:   begin wdata_c = {4{store_data[7:0]}};  wstrb_c = 4'b0001 << exu_res[1:0]; end
        2'b01:   begin wdata_c = {2{store_data[15:0]}}; wstrb_c = 4'b0011 << exu_res[1:0]; end
        default: begin wdata_c = store_data;            wstrb_c = 4'b1111; end
      endcase
    end
  end

  // Load alignment and extension of the returned word
  always_comb begin
    shifted_c = mem_resp_data >> {off_q, 3'b000};
    case (func3_q)
      3'b000:  load_data_c = {{24{shifted_c[7]}}, shifted_c[7:0]};
      3'b001:  load_data_c = {{16{shifted_c[15]}}, shifted_c[15:0]};
      3'b010:  load_data_c = mem_resp_data;
      3'b100:  load_data_c = {24'h000000, shifted_c[7:0]};
      3'b101:  load_data_c = {16'h0000, shifted_c[15:0]};
      default: load_data_c = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      func3_q     <= 3'b000;
      off_q       <= 2'b00;
      in_ready_q  <= 1'b1;
      req_valid_q <= 1'b0;
      req_addr_q  <= '0;
      req_wen_q   <= 1'b0;
      req_wdata_q <= '0;
      req_wstrb_q <= 4'b0000;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            func3_q    <= func3;
            off_q      <= exu_res[1:0];
            in_ready_q <= 1'b0;
            if ((is_load_c || is_store_c) && legal_c && !misal_c) begin
              state_q     <= REQ;
              req_valid_q <= 1'b1;
              req_addr_q  <= {exu_res[31:2], 2'b00};
              req_wen_q   <= is_store_c;
              req_wdata_q <= wdata_c;
              req_wstrb_q <= wstrb_c;
            end else begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
              out_err_q   <= is_load_c || is_store_c;
              out_data_q  <= (is_load_c || is_store_c) ? '0 : exu_res;
            end
          end
        end
        REQ: begin
          if (mem_req_ready) begin
            state_q     <= WAIT;
            req_valid_q <= 1'b0;
          end
        end
        WAIT: begin
          if (mem_resp_valid) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            out_err_q   <= mem_resp_err;
            out_data_q  <= (mem_resp_err || req_wen_q) ? '0 : load_data_c;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready      = in_ready_q;
  assign mem_req_valid = req_valid_q;
  assign mem_req_addr  = req_addr_q;
  assign mem_req_wen   = req_wen_q;
  assign mem_req_wdata = req_wdata_q;
  assign mem_req_wstrb = req_wstrb_q;
  assign out_valid     = out_valid_q;
  assign out_data      = out_data_q;
  assign out_err       = out_err_q;

endmodule

// File: tb/tb_lsu_stage.sv
// Directed bench for lsu_stage: passthrough, load/store lanes, errors,
// backpressure on both handshakes and reset in the middle of a load.
module tb_lsu_stage;

  localparam logic [6:0] LOAD  = 7'b0000011;
  localparam logic [6:0] STORE = 7'b0100011;
  localparam logic [6:0] ADD   = 7'b0110011;

  logic        clk, rst_n;
  logic        in_valid, in_ready;
  logic [6:0]  opcode;
  logic [2:0]  func3;
  logic [31:0] exu_res, store_data;
  logic        mem_req_valid, mem_req_ready, mem_req_wen;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic [3:0]  mem_req_wstrb;
  logic        mem_resp_valid, mem_resp_err;
  logic [31:0] mem_resp_data;
  logic        out_valid, out_ready, out_err;
  logic [31:0] out_data;

  int total = 0;
  int bad   = 0;

  lsu_stage dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .func3(func3), .exu_res(exu_res), .store_data(store_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_wen(mem_req_wen),
    .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .mem_resp_err(mem_resp_err),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_err(out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Single-cycle instruction: passthrough or early error, no memory access
  task automatic one_op(input string tag, input logic [6:0] opc, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] e_data, input logic e_err);
    chk({tag, ":rdy0"}, 32'(in_ready), 32'd1);
    opcode = opc; func3 = f3; exu_res = addr; store_data = 32'h5555_AAAA;
    in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk({tag, ":rdy1"}, 32'(in_ready), 32'd0);
    chk({tag, ":ov"},   32'(out_valid), 32'd1);
    chk({tag, ":data"}, out_data, e_data);
    chk({tag, ":err"},  32'(out_err), 32'(e_err));
    chk({tag, ":req"},  32'(mem_req_valid), 32'd0);
    step();
    chk({tag, ":ov2"},  32'(out_valid), 32'd0);
    chk({tag, ":req2"}, 32'(mem_req_valid), 32'd0);
  endtask

  // Memory instruction against a zero-delay memory
  task automatic mem_op(input string tag, input logic [2:0] f3, input logic st,
                        input logic [31:0] addr, input logic [31:0] sd,
                        input logic [31:0] rdata, input logic rerr,
                        input logic [31:0] e_addr, input logic [31:0] e_wdata,
                        input logic [3:0] e_wstrb, input logic [31:0] e_data, input logic e_err);
    chk({tag, ":rdy0"}, 32'(in_ready), 32'd1);
    opcode = st ? STORE : LOAD; func3 = f3; exu_res = addr; store_data = sd;
    in_valid = 1'b1; mem_req_ready = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk({tag, ":rdy1"},  32'(in_ready), 32'd0);
    chk({tag, ":req"},   32'(mem_req_valid), 32'd1);
    chk({tag, ":addr"},  mem_req_addr, e_addr);
    chk({tag, ":wen"},   32'(mem_req_wen), 32'(st));
    chk({tag, ":wstrb"}, 32'(mem_req_wstrb), 32'(e_wstrb));
    if (st) chk({tag, ":wdata"}, mem_req_wdata, e_wdata);
    step();
    chk({tag, ":req_off"}, 32'(mem_req_valid), 32'd0);
    chk({tag, ":ov_wait"}, 32'(out_valid), 32'd0);
    mem_resp_valid = 1'b1; mem_resp_data = rdata; mem_resp_err = rerr;
    step();
    mem_resp_valid = 1'b0; mem_resp_err = 1'b0;
    chk({tag, ":ov"},   32'(out_valid), 32'd1);
    chk({tag, ":data"}, out_data, e_data);
    chk({tag, ":err"},  32'(out_err), 32'(e_err));
    step();
    chk({tag, ":ov2"},  32'(out_valid), 32'd0);
    chk({tag, ":rdy2"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; opcode = '0; func3 = '0; exu_res = '0; store_data = '0;
    mem_req_ready = 1'b1; mem_resp_valid = 1'b0; mem_resp_data = '0; mem_resp_err = 1'b0;
    out_ready = 1'b1;
    step(); step();
    chk("rst:in_ready", 32'(in_ready), 32'd1);
    chk("rst:req",      32'(mem_req_valid), 32'd0);
    chk("rst:addr",     mem_req_addr, 32'd0);
    chk("rst:ov",       32'(out_valid), 32'd0);
    chk("rst:data",     out_data, 32'd0);
    rst_n = 1'b1;
    step();

    // Passthrough and early-error instructions
    one_op("add",      ADD,           3'b000, 32'h1234_5678, 32'h1234_5678, 1'b0);
    one_op("lui",      7'b0110111,    3'b111, 32'hABCD_E000, 32'hABCD_E000, 1'b0);
    one_op("lw_mis1",  LOAD,          3'b010, 32'h8000_0001, 32'h0, 1'b1);
    one_op("lw_mis2",  LOAD,          3'b010, 32'h8000_0002, 32'h0, 1'b1);
    one_op("lh_mis",   LOAD,          3'b001, 32'h8000_0003, 32'h0, 1'b1);
    one_op("sw_mis",   STORE,         3'b010, 32'h8000_0002, 32'h0, 1'b1);
    one_op("ld_f011",  LOAD,          3'b011, 32'h8000_0000, 32'h0, 1'b1);
    one_op("st_f100",  STORE,         3'b100, 32'h8000_0000, 32'h0, 1'b1);

    // Loads and stores with hand-computed lanes and extensions
    mem_op("lb",   3'b000, 1'b0, 32'h8000_0003, 32'h0, 32'h80AA_BBCC, 1'b0,
           32'h8000_0000, 32'h0, 4'b0000, 32'hFFFF_FF80, 1'b0);
    mem_op("lbu",  3'b100, 1'b0, 32'h8000_0003, 32'h0, 32'h80AA_BBCC, 1'b0,
           32'h8000_0000, 32'h0, 4'b0000, 32'h0000_0080, 1'b0);
    mem_op("lb1",  3'b000, 1'b0, 32'h8000_0001, 32'h0, 32'h1234_5678, 1'b0,
           32'h8000_0000, 32'h0, 4'b0000, 32'h0000_0056, 1'b0);
    mem_op("lh",   3'b001, 1'b0, 32'h8000_0002, 32'h0, 32'h80AA_BBCC, 1'b0,
           32'h8000_0000, 32'h0, 4'b0000, 32'hFFFF_80AA, 1'b0);
    mem_op("lhu",  3'b101, 1'b0, 32'h8000_0002, 32'h0, 32'h80AA_BBCC, 1'b0,
           32'h8000_0000, 32'h0, 4'b0000, 32'h0000_80AA, 1'b0);
    mem_op("lw",   3'b010, 1'b0, 32'h8000_0004, 32'h0, 32'h80AA_BBCC, 1'b0,
           32'h8000_0004, 32'h0, 4'b0000, 32'h80AA_BBCC, 1'b0);
    mem_op("lwerr", 3'b010, 1'b0, 32'h8000_0000, 32'h0, 32'hFFFF_FFFF, 1'b1,
           32'h8000_0000, 32'h0, 4'b0000, 32'h0, 1'b1);
    mem_op("sh",   3'b001, 1'b1, 32'h8000_0002, 32'hDEAD_BEEF, 32'h1111_1111, 1'b0,
           32'h8000_0000, 32'hBEEF_BEEF, 4'b1100, 32'h0, 1'b0);
    mem_op("sb",   3'b000, 1'b1, 32'h8000_0001, 32'h0000_00A5, 32'h2222_2222, 1'b0,
           32'h8000_0000, 32'hA5A5_A5A5, 4'b0010, 32'h0, 1'b0);
    mem_op("sw",   3'b010, 1'b1, 32'h8000_0008, 32'h0123_4567, 32'h3333_3333, 1'b0,
           32'h8000_0008, 32'h0123_4567, 4'b1111, 32'h0, 1'b0);

    // Backpressure on request, delayed response, stalled writeback
    opcode = LOAD; func3 = 3'b010; exu_res = 32'h0000_0010; in_valid = 1'b1;
    mem_req_ready = 1'b0; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("bp:req",   32'(mem_req_valid), 32'd1);
      chk("bp:addr",  mem_req_addr, 32'h0000_0010);
      chk("bp:wen",   32'(mem_req_wen), 32'd0);
      chk("bp:wstrb", 32'(mem_req_wstrb), 32'd0);
      chk("bp:rdy",   32'(in_ready), 32'd0);
      chk("bp:ov",    32'(out_valid), 32'd0);
      mem_resp_valid = (i == 1); mem_resp_err = (i == 1); mem_resp_data = 32'hBAD0_BAD0;
      step();
    end
    mem_resp_valid = 1'b0; mem_resp_err = 1'b0;
    chk("bp:req_last", 32'(mem_req_valid), 32'd1);
    chk("bp:ov_last",  32'(out_valid), 32'd0);
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    chk("bp:req_off", 32'(mem_req_valid), 32'd0);
    step();
    chk("bp:ov_wait", 32'(out_valid), 32'd0);
    mem_resp_valid = 1'b1; mem_resp_data = 32'hCAFE_F00D;
    step();
    mem_resp_valid = 1'b0;
    opcode = ADD; func3 = 3'b000; exu_res = 32'h00C0_FFEE; in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      chk("bp:hold_ov",   32'(out_valid), 32'd1);
      chk("bp:hold_data", out_data, 32'hCAFE_F00D);
      chk("bp:hold_err",  32'(out_err), 32'd0);
      chk("bp:hold_rdy",  32'(in_ready), 32'd0);
      step();
    end
    chk("bp:hs_data", out_data, 32'hCAFE_F00D);
    chk("bp:hs_rdy",  32'(in_ready), 32'd0);
    out_ready = 1'b1;
    step();
    chk("bp:idle_rdy", 32'(in_ready), 32'd1);
    chk("bp:idle_ov",  32'(out_valid), 32'd0);
    step();
    in_valid = 1'b0;
    chk("bp:next_ov",   32'(out_valid), 32'd1);
    chk("bp:next_data", out_data, 32'h00C0_FFEE);
    step();
    chk("bp:next_rdy", 32'(in_ready), 32'd1);

    // Reset while a load waits for its response
    opcode = LOAD; func3 = 3'b010; exu_res = 32'h0000_0020; in_valid = 1'b1; mem_req_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    chk("rw:wait_req", 32'(mem_req_valid), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("rw:rdy",   32'(in_ready), 32'd1);
    chk("rw:req",   32'(mem_req_valid), 32'd0);
    chk("rw:addr",  mem_req_addr, 32'd0);
    chk("rw:wen",   32'(mem_req_wen), 32'd0);
    chk("rw:wdata", mem_req_wdata, 32'd0);
    chk("rw:wstrb", 32'(mem_req_wstrb), 32'd0);
    chk("rw:ov",    32'(out_valid), 32'd0);
    chk("rw:data",  out_data, 32'd0);
    chk("rw:err",   32'(out_err), 32'd0);
    step();
    rst_n = 1'b1;
    mem_resp_valid = 1'b1; mem_resp_data = 32'h7777_7777;
    step();
    mem_resp_valid = 1'b0;
    chk("rw:late_ov",  32'(out_valid), 32'd0);
    chk("rw:late_rdy", 32'(in_ready), 32'd1);
    one_op("add_post", ADD, 3'b000, 32'h0BAD_CAFE, 32'h0BAD_CAFE, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lsu_stage.md
# lsu_stage

Multicycle load/store stage sitting directly downstream of the execute stage. It latches the execute result (the effective address or the ALU result) together with opcode/func3 and the store operand. For loads and stores it runs a valid/ready request plus a response transaction on a variable-latency data-memory port. It aligns and sign/zero-extends load data and forwards one result per instruction to writeback over a valid/ready handshake. Non-memory instructions pass through with one cycle of latency.

## Interface
- No parameters; datapath fixed at 32 bits, byte-addressed, 4-byte memory word.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  execute result valid
- in_ready  out  1  stage can accept; equals (state == IDLE)
- opcode  in  7  instruction opcode
- func3  in  3  instruction func3
- exu_res  in  32  execute result (effective address for load/store)
- store_data  in  32  rs2 value for stores
- mem_req_valid  out  1  memory request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  32  word-aligned address {exu_res[31:2],2'b00}
- mem_req_wen  out  1  1 = store, 0 = load
- mem_req_wdata  out  32  lane-replicated store data
- mem_req_wstrb  out  4  byte strobes (0000 for loads)
- mem_resp_valid  in  1  response valid (one-cycle pulse)
- mem_resp_data  in  32  read word
- mem_resp_err  in  1  bus error, qualified by mem_resp_valid
- out_valid  out  1  result valid to writeback
- out_ready  in  1  writeback accepts
- out_data  out  32  load result, or passthrough exu_res for non-memory ops; 0 for stores and on error
- out_err  out  1  misaligned, illegal func3, or bus error; qualified by out_valid

## Operation
- States: IDLE, REQ, WAIT, DONE. All outputs are registered from state and latched fields.
- IDLE, on in_valid: latch opcode, func3, exu_res, store_data.
  - LOAD (0000011) or STORE (0100011), aligned, legal func3 -> REQ.
  - Misaligned (H with addr[0]=1; W with addr[1:0]!=0) or illegal func3 -> DONE with out_err=1, out_data=0. No memory access.
  - Any other opcode -> DONE with out_data=exu_res, out_err=0.
- Legal func3 values:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
- REQ: mem_req_valid=1. Address, wen, wdata and wstrb stay stable until mem_req_ready. On handshake -> WAIT.
- Store lanes, with o = addr[1:0]:
  - SB: wdata={4{d[7:0]}}, wstrb=0001<<o.
  - SH: wdata={2{d[15:0]}}, wstrb=0011<<o.
  - SW: wdata=d, wstrb=1111.
- WAIT, on mem_resp_valid -> DONE.
  - Load: select byte (mem_resp_data >> 8*o), or halfword at o (o in {0,2}).
  - LB and LH sign-extend; LBU and LHU zero-extend; LW passes through.
  - Store: out_data=0.
  - mem_resp_err=1 overrides: out_err=1, out_data=0.
- DONE: out_valid=1, out_data and out_err held stable until out_ready -> IDLE.
- mem_resp_valid outside WAIT is ignored. mem_req_ready outside REQ is ignored.

## Timing
- Reset, asynchronous and immediate:
  - state=IDLE.
  - in_ready=1.
  - mem_req_valid=0, mem_req_addr=0, mem_req_wen=0, mem_req_wdata=0, mem_req_wstrb=0.
  - out_valid=0, out_data=0, out_err=0.
- Reset asserted mid-transaction abandons it. The memory side must tolerate the dropped response.
- Input handshake in cycle T; in_ready drops in T+1.
- Non-memory, misaligned or illegal instruction: out_valid at T+1.
- Memory op, minimum latency: mem_req_valid at T+1, ready at T+1, response at T+2, out_valid at T+3.
  - Each request stall cycle adds 1. Each response wait cycle adds 1.
- Response may arrive no earlier than the cycle after the request handshake.
- out_ready low holds DONE indefinitely.
- A new instruction is accepted no earlier than the cycle after the out handshake. Throughput is at most 1 instruction per 2 cycles.
- One outstanding memory transaction at most.

## Test plan
- ADD passthrough: opcode=0110011, exu_res=0x1234_5678. Required: out_valid at T+1, out_data=0x1234_5678, out_err=0, no mem_req_valid.
- LB sign: addr=0x8000_0003, mem_resp_data=0x80AA_BBCC, zero-delay memory. Required: mem_req_addr=0x8000_0000, wstrb=0000, out_data=0xFFFF_FF80 at T+3. Repeat as LBU: 0x0000_0080.
- SH lanes: addr=0x8000_0002, store_data=0xDEAD_BEEF. Required: wdata=0xBEEF_BEEF, wstrb=1100, wen=1, out_data=0, out_err=0.
- Misaligned LW: addr=0x8000_0001. Required: out_valid at T+1, out_err=1, mem_req_valid never asserted.
- Backpressure: mem_req_ready low 3 cycles, response 2 cycles after handshake, out_ready low 2 cycles. Required:
  - mem_req fields stable throughout.
  - Stray mem_resp_valid during REQ ignored.
  - out_data held while out_ready low.
  - in_ready=0 until the cycle after the out handshake.
- Reset in WAIT: rst_n low mid-LW. Required: all outputs zero immediately, in_ready=1, late response after reset ignored, next ADD completes normally.
